sobel_window_3x3: RTL and testbench
===================================

// Module: sobel_window_3x3
// PURPOSE
//  Stage directly upstream of the Sobel operator. Takes a raster-order pixel
//  stream, one pixel per accepted beat, and stores the two previous image rows
//  in line buffers. For every interior pixel it presents the full 3x3
//  neighbourhood on x00..x22 with a valid strobe, ready for the Sobel stage.
//  Border pixels, meaning the first two rows and first two columns, produce no window.
// PARAMETERS
//  PIX_W  24   bits per pixel; default is {R,G,B} 8:8:8
//  IMG_W  640  pixels per line; minimum 3
//  IMG_H  480  lines per frame; minimum 3
// PORTS
//  clk        in   1      clock; all logic on rising edge
//  reset_n    in   1      synchronous reset, active low
//  in_valid   in   1      in_pixel is valid this cycle; no backpressure
//  in_sof     in   1      qualified by in_valid; marks the pixel as (row 0, col 0)
//  in_pixel   in   PIX_W  pixel data, raster order
//  out_valid  out  1      window taps valid; one-cycle pulse per window
//  out_last   out  1      qualified by out_valid; marks the final window of the frame
//  x00..x22   out  PIX_W  taps. xRC: R=0 is row-2, R=2 is current row; C=0 is col-2, C=2 is current col
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge) sets the following to 0:
//    out_valid, out_last, all xRC, row counter and col counter.
//    Line-buffer RAM contents are not reset.
//  - Counters:
//    col advances on each in_valid. At IMG_W-1 it wraps to 0 and row advances.
//    At (IMG_H-1, IMG_W-1) both counters wrap to 0, so the next frame needs no in_sof.
//  - in_sof with in_valid: the beat is treated as (0,0), whatever the counter state.
//    Counters then continue from (0,1).
//    Stale line-buffer data is never output, because out_valid requires row>=2.
//  - On each in_valid beat, let c = col at that beat:
//    - Taps: top = lb1[c], mid = lb0[c], bot = in_pixel.
//    - Each window row shifts left: xR0<=xR1, xR1<=xR2.
//      Then x02<=top, x12<=mid, x22<=bot.
//    - lb1[c]<=lb0[c] and lb0[c]<=in_pixel. Read-before-write at the same address.
//    - out_valid<=1 if row>=2 and col>=2 (pre-increment values), else 0.
//    - out_last<=1 if row==IMG_H-1 and col==IMG_W-1.
//  - Without in_valid: out_valid<=0 and out_last<=0; window and counters hold.
//    Gaps between beats are allowed at any point, including mid-line.
//  - Latency: 1 clk. The window for accepted pixel (r,c) is centred on (r-1,c-1).
//    It appears the cycle after that beat.
//  - Windows per frame: (IMG_W-2)*(IMG_H-2). None wrap across line edges.
//    After a line wrap, out_valid stays suppressed until col>=2 refills the window.
//  - Widths: col uses $clog2(IMG_W) bits and row uses $clog2(IMG_H) bits.
//    No arithmetic is done on pixel data.
//  - Reset mid-frame: the next beat is (0,0). No window is output until row 2 of the new frame.
// TESTING  (PIX_W=8, IMG_W=4, IMG_H=4 unless noted; pixel = {row[3:0],col[3:0]})
//  1. Full frame, sof on the first beat, in_valid held high.
//     -> out_valid one cycle after pixel 0x22: x00=00 x01=01 x02=02 x10=10 x11=11 x12=12 x20=20 x21=21 x22=22.
//     -> Next window: x00=01 .. x22=23. Then 11..33, the last of which has out_last=1.
//     -> Total of 4 pulses.
//  2. Same frame with in_valid toggling 1,0,1,0.
//     -> Same 4 windows, same values.
//     -> Each out_valid lands exactly 1 cycle after its triggering beat; no pulses during gaps.
//  3. Two back-to-back frames, in_sof only on frame 1; frame 2 pixels are 0x80|pixel.
//     -> 8 windows total. Frame 2's first window has x00=80 and x22=A2.
//  4. in_sof asserted at pixel (2,1) of frame 1, then a full frame.
//     -> No windows until new row 2, col 2.
//     -> Windows then come from the new frame's data only.
//  5. reset_n=0 for 1 cycle after pixel (2,3).
//     -> out_valid, out_last and all taps read 0 the next cycle.
//     -> A following full frame gives the exact scenario-1 output.
//  6. IMG_W=3, IMG_H=3 minimum size, full frame.
//     -> Exactly 1 window: x00=00 .. x22=22, with out_last=1.

Source files
------------

// File: rtl/sobel_window_3x3_if.sv
// Pixel-stream in, 3x3 window out, for the stage feeding the Sobel operator.
// master: pixel source and window consumer. slave: the window generator.
interface sobel_window_3x3_if #(
    parameter int PIX_W = 24
);
    logic             in_valid;
    logic             in_sof;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_last;
    logic [PIX_W-1:0] x00, x01, x02;
    logic [PIX_W-1:0] x10, x11, x12;
    logic [PIX_W-1:0] x20, x21, x22;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  out_valid, out_last,
        input  x00, x01, x02, x10, x11, x12, x20, x21, x22
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output out_valid, out_last,
        output x00, x01, x02, x10, x11, x12, x20, x21, x22
    );
endinterface

// File: rtl/sobel_window_3x3.sv
// 3x3 neighbourhood generator. Two line buffers hold the previous two rows;
// a 3x3 shift register of taps slides one column per accepted pixel. A window
// is flagged only once the taps cover a full interior neighbourhood, so
// border pixels (first two rows / columns) never produce output and stale
// line-buffer contents from a previous frame or before reset are never seen.
module sobel_window_3x3 #(
    parameter int PIX_W = 24,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               clk,
    input  logic               reset_n,
    sobel_window_3x3_if.slave  win
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]    col, col_eff, col_nxt;
    logic [RW-1:0]    row, row_eff, row_nxt;
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] top, mid;
    logic [PIX_W-1:0] tap [3][3];
    logic             win_ok, frame_end;

    // Position of the current beat (in_sof forces 0,0) and the position after it.
    always_comb begin
        col_eff = win.in_sof ? '0 : col;
        row_eff = win.in_sof ? '0 : row;
        col_nxt = col_eff + CW'(1);
        row_nxt = row_eff;
        if (col_eff == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
        end
        top       = lb1[col_eff];
        mid       = lb0[col_eff];
        win_ok    = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
        frame_end = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
    end

    // Line buffers: rotate the column down one row; reads see pre-write data.
    always_ff @(posedge clk) begin
        if (win.in_valid) begin
            lb1[col_eff] <= lb0[col_eff];
            lb0[col_eff] <= win.in_pixel;
        end
    end

    // Raster counters, window shift register and output strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col           <= '0;
            row           <= '0;
            win.out_valid <= 1'b0;
            win.out_last  <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    tap[r][c] <= '0;
        end else if (win.in_valid) begin
            col           <= col_nxt;
            row           <= row_nxt;
            win.out_valid <= win_ok;
            win.out_last  <= frame_end;
            for (int r = 0; r < 3; r++) begin
                tap[r][0] <= tap[r][1];
                tap[r][1] <= tap[r][2];
            end
            tap[0][2] <= top;
            tap[1][2] <= mid;
            tap[2][2] <= win.in_pixel;
        end else begin
            win.out_valid <= 1'b0;
            win.out_last  <= 1'b0;
        end
    end

    assign win.x00 = tap[0][0];
    assign win.x01 = tap[0][1];
    assign win.x02 = tap[0][2];
    assign win.x10 = tap[1][0];
    assign win.x11 = tap[1][1];
    assign win.x12 = tap[1][2];
    assign win.x20 = tap[2][0];
    assign win.x21 = tap[2][1];
    assign win.x22 = tap[2][2];
endmodule

// File: tb/tb_sobel_window_3x3.sv
// Bench for sobel_window_3x3: a 4x4 instance (a) and a minimum 3x3 instance (b).
// Expected windows come from a frame-image model and are queued per instance;
// negedge monitors pop and compare taps, last flag and arrival cycle.
module tb_sobel_window_3x3;
    typedef struct {
        logic [71:0] taps;
        logic        last;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    sobel_window_3x3_if #(.PIX_W(8)) ifa ();
    sobel_window_3x3_if #(.PIX_W(8)) ifb ();

    sobel_window_3x3 #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .win     (ifa)
    );

    sobel_window_3x3 #(.PIX_W(8), .IMG_W(3), .IMG_H(3)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .win     (ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // model state: image as received, raster position, expected windows
    logic [7:0] img [2][4][4];
    int         mr [2];
    int         mc [2];
    exp_t       qa [$];
    exp_t       qb [$];
    exp_t       log_a [$];
    exp_t       log_b [$];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_beat(int id, bit sof, logic [7:0] pix);
        int r, c, w, h;
        exp_t e;
        w = (id == 0) ? 4 : 3;
        h = (id == 0) ? 4 : 3;
        if (sof) begin
            mr[id] = 0;
            mc[id] = 0;
        end
        r = mr[id];
        c = mc[id];
        img[id][r][c] = pix;
        if (r >= 2 && c >= 2) begin
            e.taps = {img[id][r-2][c-2], img[id][r-2][c-1], img[id][r-2][c],
                      img[id][r-1][c-2], img[id][r-1][c-1], img[id][r-1][c],
                      img[id][r][c-2],   img[id][r][c-1],   img[id][r][c]};
            e.last = (r == h - 1) && (c == w - 1);
            e.cyc  = cyc + 1;
            if (id == 0) qa.push_back(e);
            else         qb.push_back(e);
        end
        c++;
        if (c == w) begin
            c = 0;
            r++;
            if (r == h) r = 0;
        end
        mr[id] = r;
        mc[id] = c;
    endtask

    task automatic drive(int id, bit v, bit sof, logic [7:0] pix);
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
        ifa.in_sof   = 1'b0;
        ifb.in_valid = 1'b0;
        ifb.in_sof   = 1'b0;
        if (id == 0) begin
            ifa.in_valid = v;
            ifa.in_sof   = v & sof;
            ifa.in_pixel = pix;
        end else begin
            ifb.in_valid = v;
            ifb.in_sof   = v & sof;
            ifb.in_pixel = pix;
        end
        if (v) model_beat(id, sof, pix);
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 1'b0, 1'b0, 8'h00);
    endtask

    // gap: 0 none, 1 one idle after each beat, 2 random idles
    task automatic frame(int id, logic [7:0] base, bit sof_first, int gap);
        int w, h;
        logic [3:0] r4, c4;
        w = (id == 0) ? 4 : 3;
        h = (id == 0) ? 4 : 3;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                r4 = 4'(r);
                c4 = 4'(c);
                drive(id, 1'b1, sof_first && r == 0 && c == 0, base | {r4, c4});
                if (gap == 1) idle(1);
                if (gap == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
        end
    endtask

    task automatic do_reset(int n);
        @(posedge clk);
        #1;
        reset_n      = 1'b0;
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
        ifa.in_sof   = 1'b0;
        ifb.in_sof   = 1'b0;
        mr[0] = 0; mc[0] = 0;
        mr[1] = 0; mc[1] = 0;
        repeat (n) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(string tag);
        @(negedge clk);
        chk({tag, "_valid_a"}, ifa.out_valid, 0);
        chk({tag, "_last_a"}, ifa.out_last, 0);
        chk({tag, "_taps_a"}, {ifa.x00, ifa.x01, ifa.x02, ifa.x10, ifa.x11, ifa.x12,
                               ifa.x20, ifa.x21, ifa.x22}, 0);
        chk({tag, "_valid_b"}, ifb.out_valid, 0);
        chk({tag, "_taps_b"}, {ifb.x00, ifb.x01, ifb.x02, ifb.x10, ifb.x11, ifb.x12,
                               ifb.x20, ifb.x21, ifb.x22}, 0);
    endtask

    task automatic chk_log(string name, int id, int idx, logic [71:0] taps, logic last);
        exp_t e;
        int n;
        n = (id == 0) ? log_a.size() : log_b.size();
        if (idx >= n) begin
            checks++;
            errors++;
            $display("FAIL %s window %0d missing, only %0d seen", name, idx, n);
        end else begin
            e = (id == 0) ? log_a[idx] : log_b[idx];
            chk({name, "_taps"}, e.taps, taps);
            chk({name, "_last"}, e.last, last);
        end
    endtask

    task automatic mon(int id, logic [71:0] taps, logic last);
        exp_t e, got;
        int n;
        got.taps = taps;
        got.last = last;
        got.cyc  = cyc;
        if (id == 0) log_a.push_back(got);
        else         log_b.push_back(got);
        n = (id == 0) ? qa.size() : qb.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_window dut=%0d cycle=%0d taps=%0h required=none", id, cyc, taps);
        end else begin
            e = (id == 0) ? qa.pop_front() : qb.pop_front();
            chk("window_taps", taps, e.taps);
            chk("window_last", last, e.last);
            chk("window_cycle", cyc, e.cyc);
        end
    endtask

    // window monitors, sampling away from the rising edge
    always @(negedge clk) begin
        if (ifa.out_valid === 1'b1)
            mon(0, {ifa.x00, ifa.x01, ifa.x02, ifa.x10, ifa.x11, ifa.x12,
                    ifa.x20, ifa.x21, ifa.x22}, ifa.out_last);
        if (ifb.out_valid === 1'b1)
            mon(1, {ifb.x00, ifb.x01, ifb.x02, ifb.x10, ifb.x11, ifb.x12,
                    ifb.x20, ifb.x21, ifb.x22}, ifb.out_last);
    end

    initial begin
        int base;
        logic [7:0] pix;
        ifa.in_valid = 1'b0; ifa.in_sof = 1'b0; ifa.in_pixel = '0;
        ifb.in_valid = 1'b0; ifb.in_sof = 1'b0; ifb.in_pixel = '0;
        mr[0] = 0; mc[0] = 0; mr[1] = 0; mc[1] = 0;

        do_reset(3);
        chk_reset_outputs("reset");

        // 1: full frame, continuous valid
        base = log_a.size();
        frame(0, 8'h00, 1'b1, 0);
        idle(2);
        chk("s1_pulses", log_a.size() - base, 4);
        chk_log("s1_w0", 0, base + 0, 72'h00_01_02_10_11_12_20_21_22, 1'b0);
        chk_log("s1_w1", 0, base + 1, 72'h01_02_03_11_12_13_21_22_23, 1'b0);
        chk_log("s1_w3", 0, base + 3, 72'h11_12_13_21_22_23_31_32_33, 1'b1);

        // 2: same frame, valid toggling
        base = log_a.size();
        frame(0, 8'h00, 1'b1, 1);
        idle(2);
        chk("s2_pulses", log_a.size() - base, 4);
        chk_log("s2_w0", 0, base + 0, 72'h00_01_02_10_11_12_20_21_22, 1'b0);
        chk_log("s2_w3", 0, base + 3, 72'h11_12_13_21_22_23_31_32_33, 1'b1);

        // 3: two back-to-back frames, sof only on the first
        base = log_a.size();
        frame(0, 8'h00, 1'b1, 0);
        frame(0, 8'h80, 1'b0, 0);
        idle(2);
        chk("s3_pulses", log_a.size() - base, 8);
        chk_log("s3_f2w0", 0, base + 4, 72'h80_81_82_90_91_92_A0_A1_A2, 1'b0);

        // 4: sof arrives at (2,1) of a frame, new frame follows in full
        base = log_a.size();
        for (int i = 0; i < 9; i++) drive(0, 1'b1, i == 0, 8'((i / 4) * 16 + (i % 4)));
        frame(0, 8'h40, 1'b1, 0);
        idle(2);
        chk("s4_pulses", log_a.size() - base, 4);
        chk_log("s4_w0", 0, base + 0, 72'h40_41_42_50_51_52_60_61_62, 1'b0);

        // 5: reset after pixel (2,3), then a clean frame
        base = log_a.size();
        for (int i = 0; i < 12; i++) drive(0, 1'b1, i == 0, 8'((i / 4) * 16 + (i % 4)));
        do_reset(1);
        chk_reset_outputs("s5_reset");
        chk("s5_pre_pulses", log_a.size() - base, 2);
        base = log_a.size();
        frame(0, 8'h00, 1'b0, 0);
        idle(2);
        chk("s5_pulses", log_a.size() - base, 4);
        chk_log("s5_w0", 0, base + 0, 72'h00_01_02_10_11_12_20_21_22, 1'b0);
        chk_log("s5_w3", 0, base + 3, 72'h11_12_13_21_22_23_31_32_33, 1'b1);

        // 6: minimum 3x3 image
        base = log_b.size();
        frame(1, 8'h00, 1'b1, 0);
        idle(2);
        chk("s6_pulses", log_b.size() - base, 1);
        chk_log("s6_w0", 1, base, 72'h00_01_02_10_11_12_20_21_22, 1'b1);

        // random traffic: data, gaps, stray sof and occasional reset
        for (int i = 0; i < 400; i++) begin
            pix = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 3) do_reset(1);
            else if ($urandom_range(0, 99) < 30) idle(1);
            else drive(i % 5 == 4 ? 1 : 0, 1'b1, $urandom_range(0, 99) < 4, pix);
        end
        for (int f = 0; f < 3; f++) frame(0, 8'($urandom_range(0, 255)) & 8'hC0, f == 0, 2);
        for (int f = 0; f < 2; f++) frame(1, 8'($urandom_range(0, 255)) & 8'hC0, f == 0, 2);
        idle(3);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
